// File: rtl/mux_nto1_rr_pkg.sv
// Shared definitions for the N:1 registered mux with round-robin selection.
//   MODE_FIXED / MODE_RR : values of the mode_i input.
//   clog2()              : ceiling log2, used to size channel indices.
package mux_nto1_rr_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/mux_nto1_rr_rr_arbiter.sv
// Round-robin arbiter: grants the first requester found when scanning
// ptr_i, ptr_i+1, ..., N_CH-1, 0, ..., ptr_i-1.
//   req_i       : per-channel request
//   ptr_i       : highest-priority channel this cycle (must be < N_CH)
//   en_i        : arbitration enable; no grant when low
//   gnt_o       : one-hot grant
//   gnt_idx_o   : index of the granted channel (0 when no grant)
//   gnt_valid_o : a grant exists
module rr_arbiter #(
  parameter int N_CH  = 4,
  parameter int SEL_W = 2
) (
  input  logic [N_CH-1:0]  req_i,
  input  logic [SEL_W-1:0] ptr_i,
  input  logic             en_i,
  output logic [N_CH-1:0]  gnt_o,
  output logic [SEL_W-1:0] gnt_idx_o,
  output logic             gnt_valid_o
);

  logic [SEL_W:0]   sum;
  logic [SEL_W-1:0] idx;

  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    sum         = '0;
    idx         = '0;
    for (int off = 0; off < N_CH; off++) begin
      // Wrapped candidate index; one extra bit keeps ptr+off from overflowing.
      sum = {1'b0, ptr_i} + (SEL_W+1)'(off);
      if (sum >= (SEL_W+1)'(N_CH)) sum = sum - (SEL_W+1)'(N_CH);
      idx = sum[SEL_W-1:0];
      if (en_i && !gnt_valid_o && req_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = idx;
        gnt_o[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_nto1_rr.sv
// N-channel to 1 mux with a registered output stage, valid/ready handshakes
// and a choice of fixed (sel_i) or round-robin channel selection.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   in_data_i      : packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid_i     : per-channel valid
//   in_ready_o     : per-channel ready, at most one bit set (the grant)
//   mode_i         : MODE_FIXED uses sel_i, MODE_RR scans from the RR pointer
//   sel_i          : channel chosen in fixed mode (no grant if >= N_CH)
//   out_data_o     : registered data of the captured beat
//   out_ch_o       : channel index of the captured beat
//   out_valid_o    : output register holds a beat (EMPTY=0 / FULL=1)
//   out_ready_i    : consumer accepts the beat
//   dbg_ptr_o      : current round-robin pointer, for observation only
//
// Handshake: a beat moves across an interface on a rising clk edge where
// valid and ready are both high. Once valid is raised the producer holds
// valid and data stable until that edge. in_ready_o never depends on a
// transfer being consumed later; out_valid_o never drops without an accept.
module mux_nto1_rr
  import mux_nto1_rr_pkg::*;
#(
  parameter  int WIDTH = 2,
  parameter  int N_CH  = 4,
  localparam int SEL_W = clog2(N_CH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N_CH*WIDTH-1:0] in_data_i,
  input  logic [N_CH-1:0]       in_valid_i,
  output logic [N_CH-1:0]       in_ready_o,
  input  logic                  mode_i,
  input  logic [SEL_W-1:0]      sel_i,
  output logic [WIDTH-1:0]      out_data_o,
  output logic [SEL_W-1:0]      out_ch_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [SEL_W-1:0]      dbg_ptr_o
);

  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_ch_q,    out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] ptr_q,       ptr_d;

  // The register can take a new beat when empty or when its beat leaves
  // on this same edge, which keeps one beat per cycle with a single stage.
  logic load;
  assign load = ~out_valid_q | out_ready_i;

  // Round-robin path
  logic [N_CH-1:0]  rr_gnt;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_valid;

  rr_arbiter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_arb (
    .req_i       (in_valid_i),
    .ptr_i       (ptr_q),
    .en_i        (load & ~rst_i & (mode_i == MODE_RR)),
    .gnt_o       (rr_gnt),
    .gnt_idx_o   (rr_idx),
    .gnt_valid_o (rr_valid)
  );

  // Fixed path; an out-of-range sel_i (non power-of-two N_CH) never grants.
  logic sel_in_range;
  logic fx_valid;
  assign sel_in_range = ({1'b0, sel_i} < (SEL_W+1)'(N_CH));
  assign fx_valid     = load & ~rst_i & (mode_i == MODE_FIXED) &
                        sel_in_range && in_valid_i[sel_i];

  logic             grant_valid;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_data;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    in_ready_o  = '0;
    if (mode_i == MODE_RR) begin
      grant_valid = rr_valid;
      grant_idx   = rr_idx;
      in_ready_o  = rr_gnt;
    end else if (fx_valid) begin
      grant_valid = 1'b1;
      grant_idx   = sel_i;
      in_ready_o  = N_CH'(1) << sel_i;
    end
  end

  assign grant_data = in_data_i[int'(grant_idx)*WIDTH +: WIDTH];

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (grant_valid) begin
      out_data_d  = grant_data;
      out_ch_d    = grant_idx;
      out_valid_d = 1'b1;
      if (mode_i == MODE_RR)
        ptr_d = (grant_idx == SEL_W'(N_CH-1)) ? '0 : grant_idx + 1'b1;
    end else if (load) begin
      // Beat accepted (or register already empty) with nothing new to take.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_ch_o    = out_ch_q;
  assign out_valid_o = out_valid_q;
  assign dbg_ptr_o   = ptr_q;

endmodule

// File: tb/tb_mux_nto1_rr.sv
module tb_mux_nto1_rr;

  // ---------------- clock / reset ----------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT: WIDTH=2, N_CH=4
  logic       rst;
  logic [7:0] in_data;
  logic [3:0] in_valid;
  logic [3:0] in_ready;
  logic       mode;
  logic [1:0] sel;
  logic [1:0] out_data;
  logic [1:0] out_ch;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] dbg_ptr;

  // second DUT: WIDTH=2, N_CH=3 (out-of-range sel)
  logic       rst3;
  logic [5:0] in_data3;
  logic [2:0] in_valid3;
  logic [2:0] in_ready3;
  logic [1:0] sel3;
  logic [1:0] out_data3;
  logic [1:0] out_ch3;
  logic       out_valid3;
  logic [1:0] dbg_ptr3;

  mux_nto1_rr #(.WIDTH(2), .N_CH(4)) dut (
    .clk_i(clk), .rst_i(rst), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .mode_i(mode), .sel_i(sel), .out_data_o(out_data),
    .out_ch_o(out_ch), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .dbg_ptr_o(dbg_ptr)
  );

  mux_nto1_rr #(.WIDTH(2), .N_CH(3)) dut3 (
    .clk_i(clk), .rst_i(rst3), .in_data_i(in_data3), .in_valid_i(in_valid3),
    .in_ready_o(in_ready3), .mode_i(1'b0), .sel_i(sel3), .out_data_o(out_data3),
    .out_ch_o(out_ch3), .out_valid_o(out_valid3), .out_ready_i(1'b1),
    .dbg_ptr_o(dbg_ptr3)
  );

  // ---------------- scoreboard / model ----------------
  logic [3:0] exp_q[$];   // {ch, data} of each beat expected in out regs
  int         m_ptr;
  bit         m_ov;
  int         tests;
  int         fails;

  // Grant the model expects for the current inputs, -1 if none.
  function automatic int predict_grant();
    int c;
    if (rst) return -1;
    if (m_ov && !out_ready) return -1;
    if (mode == 1'b0) return in_valid[sel] ? int'(sel) : -1;
    for (int k = 0; k < 4; k++) begin
      c = (m_ptr + k) % 4;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int g;
    g = predict_grant();
    return (g < 0) ? 4'b0000 : (4'b0001 << g);
  endfunction

  // Driver: advance one clock, pushing any predicted beat and updating the model.
  task automatic tick();
    int g;
    g = predict_grant();
    if (rst) begin
      m_ov  = 1'b0;
      m_ptr = 0;
    end else if (g >= 0) begin
      exp_q.push_back({2'(g), in_data[g*2 +: 2]});
      m_ov = 1'b1;
      if (mode) m_ptr = (g + 1) % 4;
    end else if (!m_ov || out_ready) begin
      m_ov = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [3:0] e;
    rst = 1'b1; mode = 1'b1; sel = 2'd0; out_ready = 1'b1;
    in_valid = 4'b1111; in_data = 8'b11_10_01_00;
    #1;
    tests++;
    if (in_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready_comb: got %b need 0000", in_ready); end
    tick(); tick();
    tests++;
    if (out_valid !== 1'b0 || out_data !== 2'd0 || out_ch !== 2'd0 || dbg_ptr !== 2'd0 || in_ready !== 4'b0000) begin
      fails++;
      $display("FAIL reset_state: got v=%b d=%0d ch=%0d ptr=%0d rdy=%b need 0 0 0 0 0000",
               out_valid, out_data, out_ch, dbg_ptr, in_ready);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (in_ready !== 4'b0001 || in_ready !== exp_ready()) begin fails++; $display("FAIL reset_first_rr: got %b need 0001", in_ready); end
    tick();
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tests++;
      if (out_valid !== 1'b1 || {out_ch, out_data} !== e) begin fails++; $display("FAIL reset_first_beat: got v=%b %h need v=1 %h", out_valid, {out_ch, out_data}, e); end
    end
  endtask

  task automatic test_fixed();
    logic [3:0] e;
    mode = 1'b0; sel = 2'd2; in_data = 8'b11_10_01_00; in_valid = 4'b0100;
    #1;
    tests++;
    if (in_ready !== 4'b0100 || in_ready !== exp_ready()) begin fails++; $display("FAIL fixed_ready: got %b need 0100", in_ready); end
    tick();
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tests++;
      if (out_valid !== 1'b1 || {out_ch, out_data} !== e) begin fails++; $display("FAIL fixed_beat: got v=%b %h need v=1 %h", out_valid, {out_ch, out_data}, e); end
    end
    tests++;
    if (out_data !== 2'd2 || out_ch !== 2'd2 || out_valid !== 1'b1) begin fails++; $display("FAIL fixed_out: got d=%0d ch=%0d v=%b need 2 2 1", out_data, out_ch, out_valid); end
    in_valid = 4'b0000;
    #1;
    tests++;
    if (in_ready !== 4'b0000) begin fails++; $display("FAIL fixed_idle_ready: got %b need 0000", in_ready); end
    tick();
    tests++;
    if (out_valid !== 1'b0 || out_data !== 2'd2 || out_ch !== 2'd2) begin fails++; $display("FAIL fixed_drain: got v=%b d=%0d ch=%0d need 0 2 2", out_valid, out_data, out_ch); end
    sel = 2'd1; in_valid = 4'b1101;
    #1;
    tests++;
    if (in_ready !== 4'b0000 || in_ready !== exp_ready()) begin fails++; $display("FAIL fixed_sel_invalid_ready: got %b need 0000", in_ready); end
    tick();
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL fixed_sel_invalid_out: got v=%b need 0", out_valid); end
  endtask

  task automatic test_rr_fair();
    logic [3:0] e;
    rst = 1'b1; tick(); rst = 1'b0;
    mode = 1'b1; out_ready = 1'b1; in_valid = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      if (i == 8) in_valid = 4'b1010;
      #1;
      tests++;
      if (in_ready !== exp_ready()) begin fails++; $display("FAIL rr_ready[%0d]: got %b need %b", i, in_ready, exp_ready()); end
      tick();
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front(); tests++;
        if (out_valid !== 1'b1 || {out_ch, out_data} !== e) begin fails++; $display("FAIL rr_beat[%0d]: got v=%b %h need v=1 %h", i, out_valid, {out_ch, out_data}, e); end
      end
      tests++;
      if (int'(out_ch) != ((i < 8) ? (i % 4) : ((i % 2) ? 3 : 1))) begin
        fails++; $display("FAIL rr_seq[%0d]: got ch=%0d", i, out_ch);
      end
      // Refresh only the channel just consumed, keeping pending data stable.
      in_data[out_ch*2 +: 2] = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] e;
    rst = 1'b1; tick(); rst = 1'b0;
    mode = 1'b1; out_ready = 1'b1; in_data = 8'b11_10_01_00; in_valid = 4'b0010;
    #1;
    tests++;
    if (in_ready !== 4'b0010) begin fails++; $display("FAIL bp_first_ready: got %b need 0010", in_ready); end
    tick();
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tests++;
      if (out_valid !== 1'b1 || {out_ch, out_data} !== e) begin fails++; $display("FAIL bp_first_beat: got v=%b %h need v=1 %h", out_valid, {out_ch, out_data}, e); end
    end
    out_ready = 1'b0; in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++;
      if (in_ready !== 4'b0000) begin fails++; $display("FAIL bp_stall_ready[%0d]: got %b need 0000", i, in_ready); end
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_data !== 2'd1 || out_ch !== 2'd1 || dbg_ptr !== 2'd2) begin
        fails++; $display("FAIL bp_hold[%0d]: got v=%b d=%0d ch=%0d ptr=%0d need 1 1 1 2", i, out_valid, out_data, out_ch, dbg_ptr);
      end
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 4'b0100 || in_ready !== exp_ready()) begin fails++; $display("FAIL bp_release_ready: got %b need 0100", in_ready); end
    tick();
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tests++;
      if (out_valid !== 1'b1 || {out_ch, out_data} !== e) begin fails++; $display("FAIL bp_no_bubble: got v=%b %h need v=1 %h", out_valid, {out_ch, out_data}, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] e;
    tests++;
    if (dbg_ptr !== 2'd3 || out_valid !== 1'b1) begin fails++; $display("FAIL rstmid_pre: got ptr=%0d v=%b need 3 1", dbg_ptr, out_valid); end
    rst = 1'b1; in_valid = 4'b1111;
    tick();
    tests++;
    if (out_valid !== 1'b0 || dbg_ptr !== 2'd0 || out_data !== 2'd0 || out_ch !== 2'd0) begin
      fails++; $display("FAIL rstmid_state: got v=%b ptr=%0d d=%0d ch=%0d need 0 0 0 0", out_valid, dbg_ptr, out_data, out_ch);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (in_ready !== 4'b0001 || in_ready !== exp_ready()) begin fails++; $display("FAIL rstmid_grant: got %b need 0001", in_ready); end
    tick();
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tests++;
      if (out_valid !== 1'b1 || {out_ch, out_data} !== e) begin fails++; $display("FAIL rstmid_beat: got v=%b %h need v=1 %h", out_valid, {out_ch, out_data}, e); end
    end
  endtask

  task automatic test_n3_sel_range();
    rst3 = 1'b1;
    @(posedge clk); #1;
    rst3 = 1'b0; in_data3 = 6'b10_01_00; in_valid3 = 3'b111; sel3 = 2'd3;
    #1;
    tests++;
    if (in_ready3 !== 3'b000) begin fails++; $display("FAIL n3_sel3_ready: got %b need 000", in_ready3); end
    @(posedge clk); #1;
    tests++;
    if (out_valid3 !== 1'b0) begin fails++; $display("FAIL n3_sel3_out: got v=%b need 0", out_valid3); end
    sel3 = 2'd2;
    #1;
    tests++;
    if (in_ready3 !== 3'b100) begin fails++; $display("FAIL n3_sel2_ready: got %b need 100", in_ready3); end
    @(posedge clk); #1;
    tests++;
    if (out_valid3 !== 1'b1 || out_data3 !== 2'd2 || out_ch3 !== 2'd2) begin
      fails++; $display("FAIL n3_sel2_out: got v=%b d=%0d ch=%0d need 1 2 2", out_valid3, out_data3, out_ch3);
    end
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    tests = 0; fails = 0; m_ptr = 0; m_ov = 1'b0;
    rst = 1'b1; rst3 = 1'b1; mode = 1'b1; sel = 2'd0; out_ready = 1'b1;
    in_data = '0; in_valid = '0; in_data3 = '0; in_valid3 = '0; sel3 = '0;
    test_reset();
    test_fixed();
    test_rr_fair();
    test_backpressure();
    test_reset_mid();
    test_n3_sel_range();
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_drain: got %0d pending need 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
